// File: rtl/mp_enq_packer_pkg.sv
// Shared helpers for the L1D request-path packer: bit counting over a fixed
// maximum width, with the caller supplying the live width.
package mp_enq_packer_pkg;

    localparam int UTIL_MAXW = 32;

    typedef logic [UTIL_MAXW-1:0] util_vec_t;

    function automatic int popcount(input util_vec_t v, input int w);
        int n;
        n = 0;
        for (int i = 0; i < UTIL_MAXW; i++) begin
            if (i < w && v[i]) n++;
        end
        return n;
    endfunction

    // Number of consecutive ones starting at bit 0; stops at the first zero.
    function automatic int lead_ones(input util_vec_t v, input int w);
        int n;
        bit run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < UTIL_MAXW; i++) begin
            if (run && i < w && v[i]) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/mp_enq_packer_if.sv
// Upstream request lanes and downstream FIFO enqueue lanes of the packer.
interface mp_enq_packer_if #(
    parameter type payload_t = logic [3:0],
    parameter int  IN_WIDTH  = 4,
    parameter int  OUT_WIDTH = 4
);
    logic [IN_WIDTH-1:0]  in_vld_i;
    payload_t             in_payload_i [IN_WIDTH];
    logic                 in_rdy_o;
    logic [OUT_WIDTH-1:0] out_vld_o;
    payload_t             out_payload_o [OUT_WIDTH];
    logic [OUT_WIDTH-1:0] out_rdy_i;
    logic                 flush_i;

    modport master (
        output in_vld_i, in_payload_i, out_rdy_i, flush_i,
        input  in_rdy_o, out_vld_o, out_payload_o
    );

    modport slave (
        input  in_vld_i, in_payload_i, out_rdy_i, flush_i,
        output in_rdy_o, out_vld_o, out_payload_o
    );
endinterface

// File: rtl/mp_enq_packer_lane_compactor.sv
// Combinational compaction of sparse-valid lanes into a dense, lane-ordered
// vector; each valid lane lands at the count of valid lanes below it.
module mp_enq_packer_lane_compactor
    import mp_enq_packer_pkg::*;
#(
    parameter type payload_t = logic [3:0],
    parameter int  W         = 4,
    parameter int  CW        = $clog2(W + 1)
) (
    input  logic [W-1:0]  vld_i,
    input  payload_t      payload_i [W],
    output payload_t      dense_o [W],
    output logic [CW-1:0] cnt_o
);
    logic [CW-1:0] pfx [W];

    always_comb begin
        for (int i = 0; i < W; i++) begin
            pfx[i] = CW'(popcount(util_vec_t'(vld_i) &
                                  ((util_vec_t'(1) << i) - util_vec_t'(1)), W));
        end
    end

    always_comb begin
        for (int j = 0; j < W; j++) begin
            dense_o[j] = '0;
            for (int i = 0; i < W; i++) begin
                if (vld_i[i] && pfx[i] == CW'(j)) dense_o[j] = payload_i[i];
            end
        end
        cnt_o = CW'(popcount(util_vec_t'(vld_i), W));
    end

endmodule

// File: rtl/mp_enq_packer.sv
// Packs sparse upstream request lanes into a shift-ordered staging buffer and
// presents a dense, prefix-valid multi-lane enqueue to the FIFO.
module mp_enq_packer
    import mp_enq_packer_pkg::*;
#(
    parameter type payload_t = logic [3:0],
    parameter int  IN_WIDTH  = 4,
    parameter int  OUT_WIDTH = 4
) (
    input logic            clk,
    input logic            rst,
    mp_enq_packer_if.slave bus
);
    localparam int CAP    = 2 * IN_WIDTH;
    localparam int CNT_W  = $clog2(CAP + 1);
    localparam int M_W    = $clog2(IN_WIDTH + 1);
    localparam int SIDX_W = (CAP > 1) ? $clog2(CAP) : 1;
    localparam int DIDX_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    payload_t             stage_q [CAP];
    payload_t             stage_d [CAP];
    logic                 in_rdy;
    logic [IN_WIDTH-1:0]  acc_vld;
    payload_t             dense [IN_WIDTH];
    logic [M_W-1:0]       acc_cnt;
    logic [OUT_WIDTH-1:0] out_vld;
    logic [OUT_WIDTH-1:0] out_fire;
    int                   k;
    int                   base;
    int                   next_cnt;

    // Readiness depends on occupancy alone, so a whole group always fits.
    assign in_rdy  = (int'(cnt_q) <= CAP - IN_WIDTH);
    assign acc_vld = bus.in_vld_i & {IN_WIDTH{in_rdy}};

    mp_enq_packer_lane_compactor #(
        .payload_t (payload_t),
        .W         (IN_WIDTH),
        .CW        (M_W)
    ) u_compactor (
        .vld_i     (acc_vld),
        .payload_i (bus.in_payload_i),
        .dense_o   (dense),
        .cnt_o     (acc_cnt)
    );

    always_comb begin
        out_vld = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_vld[i] = (int'(cnt_q) > i);
        end
    end

    assign out_fire      = out_vld & bus.out_rdy_i;
    assign bus.in_rdy_o  = in_rdy;
    assign bus.out_vld_o = out_vld;

    for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_out
        if (g < CAP) begin : g_lane
            assign bus.out_payload_o[g] = stage_q[g];
        end else begin : g_tie
            assign bus.out_payload_o[g] = '0;
        end
    end

    // Only the unbroken run of firing lanes from lane 0 counts as consumed.
    always_comb begin
        k        = lead_ones(util_vec_t'(out_fire), OUT_WIDTH);
        base     = int'(cnt_q) - k;
        next_cnt = base + int'(acc_cnt);
        for (int j = 0; j < CAP; j++) begin
            stage_d[j] = stage_q[j];
            if (j + k < int'(cnt_q)) begin
                stage_d[j] = stage_q[SIDX_W'(j + k)];
            end else if (j >= base && j < next_cnt) begin
                stage_d[j] = dense[DIDX_W'(j - base)];
            end
        end
        cnt_d = bus.flush_i ? '0 : CNT_W'(next_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Payload storage needs no reset; validity is carried by cnt_q.
    always_ff @(posedge clk) begin
        for (int j = 0; j < CAP; j++) begin
            stage_q[j] <= stage_d[j];
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        bus.flush_i || next_cnt <= CAP);

endmodule

// File: tb/tb_mp_enq_packer.sv
// Scoreboard bench for mp_enq_packer: staged entries are queued on accept and
// compared lane by lane while presented, popped when consumed.
module tb_mp_enq_packer;
    localparam int W   = 4;
    localparam int CAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mp_enq_packer_if #(.payload_t(logic [3:0]), .IN_WIDTH(W), .OUT_WIDTH(W)) bus ();

    mp_enq_packer #(.payload_t(logic [3:0]), .IN_WIDTH(W), .OUT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [3:0] sb [$];

    task automatic drive(input logic [3:0] vld, input logic [15:0] pay,
                         input logic [3:0] rdy, input logic flush);
        int n;
        int k;
        bit mrdy;
        bus.in_vld_i  = vld;
        for (int i = 0; i < W; i++) bus.in_payload_i[i] = pay[i*4 +: 4];
        bus.out_rdy_i = rdy;
        bus.flush_i   = flush;
        n    = sb.size();
        mrdy = (n <= CAP - W);
        k    = 0;
        while (k < W && k < n && rdy[k]) k++;
        if (flush) begin
            sb.delete();
        end else begin
            repeat (k) void'(sb.pop_front());
            if (mrdy) for (int i = 0; i < W; i++) if (vld[i]) sb.push_back(pay[i*4 +: 4]);
        end
        @(posedge clk);
        #1;
        bus.in_vld_i  = '0;
        bus.out_rdy_i = '0;
        bus.flush_i   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (bus.out_vld_o !== 4'b0000) begin bad++; $display("FAIL reset_vld: got %b want 0000", bus.out_vld_o); end
        total++; if (bus.in_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", bus.in_rdy_o); end
        total++; if (dut.cnt_q !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sparse();
        drive(4'b1010, 16'hDCBA, 4'b0000, 1'b0);
        total++; if (bus.out_vld_o !== 4'b0011) begin bad++; $display("FAIL sparse_vld: got %b want 0011", bus.out_vld_o); end
        total++; if (bus.out_payload_o[0] !== 4'hB) begin bad++; $display("FAIL sparse_lane0: got %h want B", bus.out_payload_o[0]); end
        total++; if (bus.out_payload_o[1] !== 4'hD) begin bad++; $display("FAIL sparse_lane1: got %h want D", bus.out_payload_o[1]); end
        total++; if (dut.cnt_q !== 4'd2) begin bad++; $display("FAIL sparse_cnt: got %0d want 2", dut.cnt_q); end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
        total++; if (bus.out_vld_o !== 4'b0000) begin bad++; $display("FAIL sparse_drain: got %b want 0000", bus.out_vld_o); end
    endtask

    task automatic test_streaming();
        logic [15:0] pay;
        for (int g = 0; g < 20; g++) begin
            pay = 16'($urandom);
            total++; if (bus.in_rdy_o !== 1'b1) begin bad++; $display("FAIL stream_rdy g%0d: got %b want 1", g, bus.in_rdy_o); end
            drive(4'b1111, pay, 4'b1111, 1'b0);
            total++; if (bus.out_vld_o !== 4'b1111) begin bad++; $display("FAIL stream_vld g%0d: got %b want 1111", g, bus.out_vld_o); end
            for (int i = 0; i < W; i++) begin
                total++;
                if (bus.out_payload_o[i] !== pay[i*4 +: 4]) begin bad++; $display("FAIL stream_lane g%0d l%0d: got %h want %h", g, i, bus.out_payload_o[i], pay[i*4 +: 4]); end
            end
        end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
        total++; if (bus.out_vld_o !== 4'b0000) begin bad++; $display("FAIL stream_drain: got %b want 0000", bus.out_vld_o); end
    endtask

    task automatic test_fill();
        drive(4'b1111, 16'h3210, 4'b0000, 1'b0);
        total++; if (bus.in_rdy_o !== 1'b1) begin bad++; $display("FAIL fill_rdy1: got %b want 1", bus.in_rdy_o); end
        drive(4'b1111, 16'h7654, 4'b0000, 1'b0);
        total++; if (dut.cnt_q !== 4'd8) begin bad++; $display("FAIL fill_cnt8: got %0d want 8", dut.cnt_q); end
        total++; if (bus.in_rdy_o !== 1'b0) begin bad++; $display("FAIL fill_rdy0: got %b want 0", bus.in_rdy_o); end
        drive(4'b1111, 16'hBA98, 4'b0000, 1'b0);
        total++; if (dut.cnt_q !== 4'd8) begin bad++; $display("FAIL fill_hold: got %0d want 8", dut.cnt_q); end
        total++; if (bus.out_payload_o[0] !== 4'h0) begin bad++; $display("FAIL fill_head: got %h want 0", bus.out_payload_o[0]); end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
        total++; if (dut.cnt_q !== 4'd4) begin bad++; $display("FAIL fill_cnt4: got %0d want 4", dut.cnt_q); end
        total++; if (bus.in_rdy_o !== 1'b1) begin bad++; $display("FAIL fill_rdy_back: got %b want 1", bus.in_rdy_o); end
        for (int i = 0; i < W; i++) begin
            total++;
            if (bus.out_payload_o[i] !== 4'(4 + i)) begin bad++; $display("FAIL fill_lane l%0d: got %h want %h", i, bus.out_payload_o[i], 4'(4 + i)); end
        end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
    endtask

    task automatic test_partial();
        drive(4'b1111, 16'h4321, 4'b0000, 1'b0);
        drive(4'b0001, 16'h0005, 4'b0000, 1'b0);
        total++; if (dut.cnt_q !== 4'd5) begin bad++; $display("FAIL part_cnt5: got %0d want 5", dut.cnt_q); end
        drive(4'b0000, 16'h0000, 4'b0011, 1'b0);
        total++; if (dut.cnt_q !== 4'd3) begin bad++; $display("FAIL part_cnt3: got %0d want 3", dut.cnt_q); end
        total++; if (bus.out_vld_o !== 4'b0111) begin bad++; $display("FAIL part_vld: got %b want 0111", bus.out_vld_o); end
        total++; if (bus.out_payload_o[0] !== 4'h3) begin bad++; $display("FAIL part_lane0: got %h want 3", bus.out_payload_o[0]); end
        total++; if (bus.out_payload_o[2] !== 4'h5) begin bad++; $display("FAIL part_lane2: got %h want 5", bus.out_payload_o[2]); end
        drive(4'b0000, 16'h0000, 4'b0101, 1'b0);
        total++; if (dut.cnt_q !== 4'd2) begin bad++; $display("FAIL gap_cnt: got %0d want 2", dut.cnt_q); end
        total++; if (bus.out_payload_o[0] !== 4'h4) begin bad++; $display("FAIL gap_lane0: got %h want 4", bus.out_payload_o[0]); end
        total++; if (bus.out_payload_o[1] !== 4'h5) begin bad++; $display("FAIL gap_lane1: got %h want 5", bus.out_payload_o[1]); end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
    endtask

    task automatic test_simul();
        drive(4'b0111, 16'h0CBA, 4'b0000, 1'b0);
        drive(4'b0111, 16'h0FED, 4'b0111, 1'b0);
        total++; if (dut.cnt_q !== 4'd3) begin bad++; $display("FAIL simul_cnt: got %0d want 3", dut.cnt_q); end
        total++; if (bus.out_payload_o[0] !== 4'hD) begin bad++; $display("FAIL simul_lane0: got %h want D", bus.out_payload_o[0]); end
        total++; if (bus.out_payload_o[1] !== 4'hE) begin bad++; $display("FAIL simul_lane1: got %h want E", bus.out_payload_o[1]); end
        total++; if (bus.out_payload_o[2] !== 4'hF) begin bad++; $display("FAIL simul_lane2: got %h want F", bus.out_payload_o[2]); end
        drive(4'b1001, 16'h9008, 4'b0001, 1'b0);
        total++; if (dut.cnt_q !== 4'd4) begin bad++; $display("FAIL simul2_cnt: got %0d want 4", dut.cnt_q); end
        total++; if (bus.out_payload_o[2] !== 4'h8) begin bad++; $display("FAIL simul2_lane2: got %h want 8", bus.out_payload_o[2]); end
        total++; if (bus.out_payload_o[3] !== 4'h9) begin bad++; $display("FAIL simul2_lane3: got %h want 9", bus.out_payload_o[3]); end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
    endtask

    task automatic test_flush();
        drive(4'b1111, 16'h1234, 4'b0000, 1'b0);
        drive(4'b0011, 16'h0056, 4'b0000, 1'b0);
        total++; if (dut.cnt_q !== 4'd6) begin bad++; $display("FAIL flush_pre: got %0d want 6", dut.cnt_q); end
        drive(4'b1111, 16'hFFFF, 4'b1111, 1'b1);
        total++; if (dut.cnt_q !== 4'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", dut.cnt_q); end
        total++; if (bus.out_vld_o !== 4'b0000) begin bad++; $display("FAIL flush_vld: got %b want 0000", bus.out_vld_o); end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
        total++; if (bus.out_vld_o !== 4'b0000) begin bad++; $display("FAIL flush_after: got %b want 0000", bus.out_vld_o); end
        drive(4'b0001, 16'h0007, 4'b0000, 1'b0);
        total++; if (bus.out_payload_o[0] !== 4'h7) begin bad++; $display("FAIL flush_reuse: got %h want 7", bus.out_payload_o[0]); end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(4'b1111, 16'h8765, 4'b0000, 1'b0);
        #2 rst = 1'b0;
        sb.delete();
        #1;
        total++; if (bus.out_vld_o !== 4'b0000) begin bad++; $display("FAIL areset_vld: got %b want 0000", bus.out_vld_o); end
        total++; if (bus.in_rdy_o !== 1'b1) begin bad++; $display("FAIL areset_rdy: got %b want 1", bus.in_rdy_o); end
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0011, 16'h00BA, 4'b0000, 1'b0);
        total++; if (bus.out_vld_o !== 4'b0011) begin bad++; $display("FAIL areset_accept: got %b want 0011", bus.out_vld_o); end
        total++; if (bus.out_payload_o[1] !== 4'hB) begin bad++; $display("FAIL areset_lane1: got %h want B", bus.out_payload_o[1]); end
        drive(4'b0000, 16'h0000, 4'b1111, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] shapes [5];
        logic [3:0] rdy;
        shapes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int c = 0; c < 40; c++) begin
            rdy = shapes[$urandom_range(0, 4)];
            drive(4'($urandom_range(0, 15)), 16'($urandom), rdy, 1'b0);
            total++; if (bus.in_rdy_o !== (sb.size() <= CAP - W)) begin bad++; $display("FAIL rand_rdy c%0d: got %b want %b", c, bus.in_rdy_o, (sb.size() <= CAP - W)); end
            total++; if (dut.cnt_q !== 4'(sb.size())) begin bad++; $display("FAIL rand_cnt c%0d: got %0d want %0d", c, dut.cnt_q, sb.size()); end
            for (int i = 0; i < W; i++) begin
                total++;
                if (bus.out_vld_o[i] !== (i < sb.size())) begin bad++; $display("FAIL rand_vld c%0d l%0d: got %b", c, i, bus.out_vld_o[i]); end
                else if (i < sb.size() && bus.out_payload_o[i] !== sb[i]) begin bad++; $display("FAIL rand_lane c%0d l%0d: got %h want %h", c, i, bus.out_payload_o[i], sb[i]); end
            end
        end
    endtask

    initial begin
        bus.in_vld_i  = '0;
        for (int i = 0; i < W; i++) bus.in_payload_i[i] = '0;
        bus.out_rdy_i = '0;
        bus.flush_i   = 1'b0;
        test_reset();
        test_sparse();
        test_streaming();
        test_fill();
        test_partial();
        test_simul();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
